// File: rtl/traffic_pkg.sv
// Shared phase encoding and widths for the intersection controller family.
package traffic_pkg;

  localparam int unsigned PHASE_W = 4;
  localparam int unsigned DWELL_W = 8;

  // A/D are minimum green, B/E extension, C/F yellow; 0110..1111 are illegal.
  typedef enum logic [PHASE_W-1:0] {
    PH_A = 4'b0000,
    PH_B = 4'b0001,
    PH_C = 4'b0010,
    PH_D = 4'b0011,
    PH_E = 4'b0100,
    PH_F = 4'b0101
  } phase_t;

  function automatic logic [DWELL_W-1:0] dwell_sat_inc(input logic [DWELL_W-1:0] d);
    return (d == '1) ? d : d + DWELL_W'(1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clock into timing ticks; clr restarts the divider at a phase boundary.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign tick = en && (r_cnt == CNT_LAST);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Timed phase sequencer for the T1/T2 + P1/P2 intersection; feeds the LED outputter.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned GREEN_MIN = 3,
  parameter int unsigned EXT_MAX   = 5,
  parameter int unsigned YELLOW_T  = 2
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               req_p1,
  input  logic               req_p2,
  input  logic               hold,
  output logic [PHASE_W-1:0] phase,
  output logic               change,
  output logic               p1_wait,
  output logic               p2_wait,
  output logic [DWELL_W-1:0] dwell
);

  localparam logic [DWELL_W-1:0] GREEN_LAST  = DWELL_W'(GREEN_MIN - 1);
  localparam logic [DWELL_W-1:0] EXT_LAST    = DWELL_W'(EXT_MAX - 1);
  localparam logic [DWELL_W-1:0] YELLOW_LAST = DWELL_W'(YELLOW_T - 1);

  phase_t             r_phase;
  logic               r_change;
  logic               r_p1_wait;
  logic               r_p2_wait;
  logic [DWELL_W-1:0] r_dwell;

  phase_t             w_phase_nxt;
  logic               w_advance;
  logic               w_tick;
  logic               w_p1_wait_nxt;
  logic               w_p2_wait_nxt;
  logic [DWELL_W-1:0] w_dwell_nxt;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clock  (clock),
    .resetn (resetn),
    .clr    (w_advance),
    .en     (!hold),
    .tick   (w_tick)
  );

  // State register plus dwell counter and request latches.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_phase   <= PH_A;
      r_change  <= 1'b0;
      r_p1_wait <= 1'b0;
      r_p2_wait <= 1'b0;
      r_dwell   <= '0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_change  <= w_advance;
      r_p1_wait <= w_p1_wait_nxt;
      r_p2_wait <= w_p2_wait_nxt;
      r_dwell   <= w_dwell_nxt;
    end
  end

  // Next phase; only a tick can move a legal phase, an illegal code recovers at once.
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_A: if (w_tick && (r_dwell == GREEN_LAST)) w_phase_nxt = PH_B;
      PH_B: if (w_tick && (r_p1_wait || (r_dwell == EXT_LAST))) w_phase_nxt = PH_C;
      PH_C: if (w_tick && (r_dwell == YELLOW_LAST)) w_phase_nxt = PH_D;
      PH_D: if (w_tick && (r_dwell == GREEN_LAST)) w_phase_nxt = PH_E;
      PH_E: if (w_tick && (r_p2_wait || (r_dwell == EXT_LAST))) w_phase_nxt = PH_F;
      PH_F: if (w_tick && (r_dwell == YELLOW_LAST)) w_phase_nxt = PH_A;
      default: w_phase_nxt = PH_A;
    endcase
  end

  assign w_advance = (w_phase_nxt != r_phase);

  // Dwell and request latches; entering a pedestrian's green clears its wait.
  always_comb begin
    w_dwell_nxt   = r_dwell;
    w_p1_wait_nxt = r_p1_wait;
    w_p2_wait_nxt = r_p2_wait;

    if (w_advance) begin
      w_dwell_nxt = '0;
    end else if (w_tick) begin
      w_dwell_nxt = dwell_sat_inc(r_dwell);
    end

    if (w_advance && (w_phase_nxt == PH_D)) begin
      w_p1_wait_nxt = 1'b0;
    end else if (req_p1 && (r_phase != PH_D) && (r_phase != PH_E)) begin
      w_p1_wait_nxt = 1'b1;
    end

    if (w_advance && (w_phase_nxt == PH_A)) begin
      w_p2_wait_nxt = 1'b0;
    end else if (req_p2 && (r_phase != PH_A) && (r_phase != PH_B)) begin
      w_p2_wait_nxt = 1'b1;
    end
  end

  assign phase   = r_phase;
  assign change  = r_change;
  assign p1_wait = r_p1_wait;
  assign p2_wait = r_p2_wait;
  assign dwell   = r_dwell;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler with default parameters (CLK_DIV=4).
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  localparam logic [3:0] A = 4'd0, B = 4'd1, C = 4'd2, D = 4'd3, E = 4'd4, F = 4'd5;

  typedef struct {
    int         scn;
    int         cyc;
    logic       rp1;
    logic       rp2;
    logic       hld;
    logic [3:0] ph;
    logic       chg;
    logic       p1w;
    logic       p2w;
    logic [7:0] dw;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req_p1 = 1'b0;
  logic       req_p2 = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] phase;
  logic       change;
  logic       p1_wait;
  logic       p2_wait;
  logic [7:0] dwell;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int chg_cnt = 0;
  vec_t vecs[$];

  traffic_phase_scheduler dut (
    .clock   (clock),
    .resetn  (resetn),
    .req_p1  (req_p1),
    .req_p2  (req_p2),
    .hold    (hold),
    .phase   (phase),
    .change  (change),
    .p1_wait (p1_wait),
    .p2_wait (p2_wait),
    .dwell   (dwell)
  );

  always #5 clock = ~clock;

  function automatic void add(int s, int c, logic r1, logic r2, logic h,
                              logic [3:0] ph, logic cg, logic w1, logic w2, logic [7:0] d);
    vec_t v;
    v.scn = s; v.cyc = c; v.rp1 = r1; v.rp2 = r2; v.hld = h;
    v.ph = ph; v.chg = cg; v.p1w = w1; v.p2w = w2; v.dw = d;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ph, input logic cg,
                         input logic w1, input logic w2, input logic [7:0] d);
    chk({tag, " phase"}, 8'(phase), 8'(ph));
    chk({tag, " change"}, 8'(change), 8'(cg));
    chk({tag, " p1_wait"}, 8'(p1_wait), 8'(w1));
    chk({tag, " p2_wait"}, 8'(p2_wait), 8'(w2));
    chk({tag, " dwell"}, dwell, d);
  endtask

  // One clock; samples land on the falling edge, cycle index counts rising edges since release.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    if (change === 1'b1) chg_cnt++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic do_reset();
    req_p1 = 1'b0; req_p2 = 1'b0; hold = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    cyc = 0;
    chg_cnt = 0;
  endtask

  initial begin
    // Baseline: A12 B20 C8 D12 E20 F8, back to A at 80.
    add(0,  0, 0,0,0, A,0,0,0,0); add(0, 11, 0,0,0, A,0,0,0,2);
    add(0, 12, 0,0,0, B,1,0,0,0); add(0, 13, 0,0,0, B,0,0,0,0);
    add(0, 31, 0,0,0, B,0,0,0,4); add(0, 32, 0,0,0, C,1,0,0,0);
    add(0, 39, 0,0,0, C,0,0,0,1); add(0, 40, 0,0,0, D,1,0,0,0);
    add(0, 51, 0,0,0, D,0,0,0,2); add(0, 52, 0,0,0, E,1,0,0,0);
    add(0, 71, 0,0,0, E,0,0,0,4); add(0, 72, 0,0,0, F,1,0,0,0);
    add(0, 79, 0,0,0, F,0,0,0,1); add(0, 80, 0,0,0, A,1,0,0,0);
    add(0, 81, 0,0,0, A,0,0,0,0);
    // P1 pulse during cycle 2: B cut to 4 cycles, wait cleared on entry to D.
    add(1,  2, 1,0,0, A,0,0,0,0); add(1,  3, 0,0,0, A,0,1,0,0);
    add(1, 11, 0,0,0, A,0,1,0,2); add(1, 12, 0,0,0, B,1,1,0,0);
    add(1, 15, 0,0,0, B,0,1,0,0); add(1, 16, 0,0,0, C,1,1,0,0);
    add(1, 23, 0,0,0, C,0,1,0,1); add(1, 24, 0,0,0, D,1,0,0,0);
    add(1, 25, 0,0,0, D,0,0,0,0); add(1, 36, 0,0,0, E,1,0,0,0);
    // P2 held through A/B is ignored, latches in C, E cut to 4 cycles.
    add(2,  0, 0,1,0, A,0,0,0,0); add(2, 12, 0,1,0, B,1,0,0,0);
    add(2, 31, 0,1,0, B,0,0,0,4); add(2, 32, 0,1,0, C,1,0,0,0);
    add(2, 33, 0,0,0, C,0,0,1,0); add(2, 40, 0,0,0, D,1,0,1,0);
    add(2, 52, 0,0,0, E,1,0,1,0); add(2, 55, 0,0,0, E,0,0,1,0);
    add(2, 56, 0,0,0, F,1,0,1,0); add(2, 63, 0,0,0, F,0,0,1,1);
    add(2, 64, 0,0,0, A,1,0,0,0);
    // Hold through cycles 5..11 at dwell=1: A stretched to 19 cycles.
    add(3,  4, 0,0,0, A,0,0,0,1); add(3,  5, 0,0,1, A,0,0,0,1);
    add(3, 11, 0,0,1, A,0,0,0,1); add(3, 12, 0,0,0, A,0,0,0,1);
    add(3, 15, 0,0,0, A,0,0,0,2); add(3, 18, 0,0,0, A,0,0,0,2);
    add(3, 19, 0,0,0, B,1,0,0,0); add(3, 20, 0,0,0, B,0,0,0,0);

    #2;
    chk_all("in_reset", A, 0, 0, 0, 8'd0);

    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
        if (vecs[i].scn == s) begin
          step_to(vecs[i].cyc);
          chk_all($sformatf("s%0d c%0d", s, cyc), vecs[i].ph, vecs[i].chg,
                  vecs[i].p1w, vecs[i].p2w, vecs[i].dw);
          req_p1 = vecs[i].rp1;
          req_p2 = vecs[i].rp2;
          hold   = vecs[i].hld;
        end
      end
      if (s == 0) chk("baseline change count", 8'(chg_cnt), 8'd6);
    end

    // Asynchronous reset between clock edges in E with p2_wait set.
    do_reset();
    step_to(41);
    req_p2 = 1'b1;
    step();
    req_p2 = 1'b0;
    step_to(54);
    chk_all("pre_async", E, 0, 0, 1, 8'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk_all("async_rst", A, 0, 0, 0, 8'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    cyc = 0;
    step_to(11);
    chk_all("post_rst c11", A, 0, 0, 0, 8'd2);
    step();
    chk_all("post_rst c12", B, 1, 0, 0, 8'd0);

    // Illegal phase code recovers to A with a change strobe and cleared dwell.
    step_to(20);
    chk_all("pre_illegal", B, 0, 0, 0, 8'd2);
    force dut.r_phase = phase_t'(4'b0111);
    #1;
    release dut.r_phase;
    step();
    chk_all("illegal", A, 1, 0, 0, 8'd0);
    step_to(32);
    chk_all("illegal+11", A, 0, 0, 0, 8'd2);
    step();
    chk_all("illegal+12", B, 1, 0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
